// File: rtl/tube_seg_driver_if.sv
// Signal bundle between the tube device / CPU bridge and the tube pin driver.
interface tube_seg_driver_if;
  logic [3:0]  byteEn;
  logic [31:0] WD;
  logic [31:0] RD;
  logic [7:0]  code0;
  logic [7:0]  code1;
  logic [7:0]  code2;
  logic [3:0]  sel0;
  logic [3:0]  sel1;
  logic        sel2;
  logic [7:0]  seg0_o;
  logic [7:0]  seg1_o;
  logic [7:0]  seg2_o;
  logic [3:0]  an0_o;
  logic [3:0]  an1_o;
  logic        an2_o;

  modport master (
    output byteEn, WD, code0, code1, code2, sel0, sel1, sel2,
    input  RD, seg0_o, seg1_o, seg2_o, an0_o, an1_o, an2_o
  );

  modport slave (
    input  byteEn, WD, code0, code1, code2, sel0, sel1, sel2,
    output RD, seg0_o, seg1_o, seg2_o, an0_o, an1_o, an2_o
  );
endinterface

// File: rtl/tube_seg_driver.sv
// Tube pin driver: PWM dimming plus dead-time blanking on select changes; TUBE_BLINK_EN adds blink.
// Latency 1 clk from inputs to pins; no backpressure, pins update every cycle.
module tube_seg_driver #(
  parameter int PWM_DIV    = 4,
  parameter int DEAD_CYC   = 8,
  parameter int BLINK_HALF = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  tube_seg_driver_if.slave bus
);
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam logic [PW-1:0] PRE_TC  = PW'(PWM_DIV - 1);
  localparam logic [DW-1:0] DEAD_LD = DW'(DEAD_CYC);

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_ACTIVE} state_t;

  logic [7:0]    r_cfg;
  logic [PW-1:0] r_pre;
  logic [3:0]    r_pwm_cnt;
  state_t        r_state;
  logic [DW-1:0] r_dead_cnt;
  logic [8:0]    r_sel;
  logic [7:0]    r_seg0, r_seg1, r_seg2;
  logic [3:0]    r_an0, r_an1;
  logic          r_an2;

  logic [8:0]    w_sel;
  logic          w_sel_chg;
  logic          w_enable;
  logic          w_pwm_on;
  logic          w_show;
  logic          w_lit;
  logic          w_unused_bits;
  logic [7:0]    w_cfg_mask;

  assign w_sel     = {bus.sel0, bus.sel1, bus.sel2};
  assign w_sel_chg = (w_sel != r_sel);
  assign w_enable  = r_cfg[4];
  assign w_pwm_on  = (r_pwm_cnt <= r_cfg[3:0]);
  assign w_unused_bits = ^{bus.byteEn[3:1], bus.WD[31:8]};

`ifdef TUBE_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_ph;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= ~r_blink_ph;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign w_cfg_mask = 8'h3F;
  assign w_show     = w_pwm_on & ~(r_cfg[5] & r_blink_ph);
`else
  assign w_cfg_mask = 8'h1F;
  assign w_show     = w_pwm_on;
`endif

  // Pins light only when this edge leaves the FSM in (or moves it into) S_ACTIVE.
  assign w_lit = w_enable & ~w_sel_chg & w_show &
                 ((r_state == S_ACTIVE) ||
                  ((r_state == S_BLANK) && (r_dead_cnt == DW'(1))));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg     <= 8'h1F;
      r_pre     <= '0;
      r_pwm_cnt <= '0;
    end else begin
      if (bus.byteEn[0]) r_cfg <= bus.WD[7:0] & w_cfg_mask;
      if (r_pre == PRE_TC) begin
        r_pre     <= '0;
        r_pwm_cnt <= r_pwm_cnt + 4'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // Tracks the inputs through reset too, so steady selects do not re-blank after reset.
  always_ff @(posedge clk) begin
    r_sel <= w_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_BLANK;
      r_dead_cnt <= DEAD_LD;
      r_seg0     <= 8'hFF;
      r_seg1     <= 8'hFF;
      r_seg2     <= 8'hFF;
      r_an0      <= 4'b0;
      r_an1      <= 4'b0;
      r_an2      <= 1'b0;
    end else begin
      r_seg0 <= w_lit ? bus.code0 : 8'hFF;
      r_seg1 <= w_lit ? bus.code1 : 8'hFF;
      r_seg2 <= w_lit ? bus.code2 : 8'hFF;
      r_an0  <= w_lit ? bus.sel0  : 4'b0;
      r_an1  <= w_lit ? bus.sel1  : 4'b0;
      r_an2  <= w_lit ? bus.sel2  : 1'b0;
      case (r_state)
        S_OFF: begin
          if (w_enable) begin
            r_state    <= S_BLANK;
            r_dead_cnt <= DEAD_LD;
          end
        end
        S_BLANK: begin
          if (!w_enable) begin
            r_state <= S_OFF;
          end else if (w_sel_chg) begin
            r_dead_cnt <= DEAD_LD;
          end else if (r_dead_cnt == DW'(1)) begin
            r_state <= S_ACTIVE;
          end else begin
            r_dead_cnt <= r_dead_cnt - 1'b1;
          end
        end
        S_ACTIVE: begin
          if (!w_enable) begin
            r_state <= S_OFF;
          end else if (w_sel_chg) begin
            r_state    <= S_BLANK;
            r_dead_cnt <= DEAD_LD;
          end
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  assign bus.RD     = {24'b0, r_cfg};
  assign bus.seg0_o = r_seg0;
  assign bus.seg1_o = r_seg1;
  assign bus.seg2_o = r_seg2;
  assign bus.an0_o  = r_an0;
  assign bus.an1_o  = r_an1;
  assign bus.an2_o  = r_an2;
endmodule

// File: tb/tb_tube_seg_driver.sv
// Scoreboard bench for tube_seg_driver: reference model predicts pins and RD per edge.
module tb_tube_seg_driver;
  localparam int DIV  = 4;
  localparam int DEAD = 8;
  localparam int BH   = 10;
`ifdef TUBE_BLINK_EN
  localparam bit         BLINK_ON = 1'b1;
  localparam logic [7:0] CFG_MASK = 8'h3F;
`else
  localparam bit         BLINK_ON = 1'b0;
  localparam logic [7:0] CFG_MASK = 8'h1F;
`endif

  typedef struct {
    logic [32:0] pins;
    logic [31:0] rd;
  } exp_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  tube_seg_driver_if ifc ();

  tube_seg_driver #(.PWM_DIV(DIV), .DEAD_CYC(DEAD), .BLINK_HALF(BH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: modes 0=off 1=blanking 2=active; PWM and blink phases from elapsed edges.
  initial begin : model
    exp_t       e;
    logic [8:0] sel_now;
    logic [8:0] prev_sel;
    logic [7:0] cfg;
    int         mode, left, t;
    bit         en, chg, show, lit;
    mode = 1; left = DEAD; t = 0; cfg = 8'h1F; prev_sel = '0;
    forever begin
      @(posedge clk);
      sel_now = {ifc.sel0, ifc.sel1, ifc.sel2};
      lit = 1'b0;
      if (reset) begin
        mode = 1; left = DEAD; t = 0; cfg = 8'h1F;
      end else begin
        en   = cfg[4];
        chg  = (sel_now != prev_sel);
        show = (((t / DIV) % 16) <= int'(cfg[3:0])) &&
               !(BLINK_ON && cfg[5] && (((t / BH) % 2) == 1));
        if (mode == 0) begin
          if (en) begin mode = 1; left = DEAD; end
        end else if (!en) begin
          mode = 0;
        end else if (chg) begin
          mode = 1; left = DEAD;
        end else if (mode == 1) begin
          if (left == 1) begin mode = 2; lit = show; end
          else left--;
        end else begin
          lit = show;
        end
        if (ifc.byteEn[0]) cfg = ifc.WD[7:0] & CFG_MASK;
        t++;
      end
      prev_sel = sel_now;
      e.pins = lit ? {ifc.code0, ifc.code1, ifc.code2, ifc.sel0, ifc.sel1, ifc.sel2}
                   : {24'hFFFFFF, 9'h0};
      e.rd   = {24'h0, cfg};
      q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        m = q.pop_front();
        check("pins", 64'({ifc.seg0_o, ifc.seg1_o, ifc.seg2_o, ifc.an0_o, ifc.an1_o, ifc.an2_o}),
              64'(m.pins));
        check("rd", 64'(ifc.RD), 64'(m.rd));
      end
    end
  end

  task automatic write_cfg(input logic [3:0] be, input logic [31:0] wd);
    ifc.byteEn = be;
    ifc.WD     = wd;
    @(posedge clk);
    #1;
    ifc.byteEn = 4'b0;
  endtask

  task automatic count_dark(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.an0_o != 4'b0) break;
      n++;
    end
  endtask

  initial begin : driver
    int n;
    int lit_cnt;
    reset = 1'b1;
    ifc.byteEn = 4'b0; ifc.WD = 32'h0;
    ifc.code0 = 8'hC0; ifc.code1 = 8'hF9; ifc.code2 = 8'hA4;
    ifc.sel0 = 4'b0001; ifc.sel1 = 4'b0100; ifc.sel2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    count_dark(n);
    check("reset_dark_cycles", 64'(n), 64'(DEAD));
    check("reset_then_lit_an0", 64'(ifc.an0_o), 64'(4'b0001));

    write_cfg(4'b0001, 32'h13);
    @(negedge clk);
    check("rd_duty3", 64'(ifc.RD), 64'h13);
    lit_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ifc.an0_o != 4'b0) lit_cnt++;
    end
    check("duty3_lit_of_64", 64'(lit_cnt), 64'd16);

    write_cfg(4'b0001, 32'h1F);
    repeat (10) @(posedge clk);
    #1 ifc.sel0 = 4'b0010;
    repeat (5) @(posedge clk);
    #1 ifc.sel0 = 4'b0100;
    @(posedge clk);
    count_dark(n);
    check("retoggle_dark_cycles", 64'(n), 64'(DEAD));
    check("retoggle_lit_an0", 64'(ifc.an0_o), 64'(4'b0100));

    write_cfg(4'b0001, 32'h0F);
    repeat (3) @(negedge clk);
    check("disabled_dark", 64'(ifc.an0_o), 64'h0);
    write_cfg(4'b0001, 32'h1F);
    @(posedge clk);
    count_dark(n);
    check("reenable_dark_cycles", 64'(n), 64'(DEAD));

    write_cfg(4'b1110, 32'hFFFFFF00);
    @(negedge clk);
    check("rd_upper_bytes_ignored", 64'(ifc.RD), 64'h1F);

    write_cfg(4'b0001, 32'h3F);
    @(negedge clk);
    check("rd_blink_bit", 64'(ifc.RD), BLINK_ON ? 64'h3F : 64'h1F);
    repeat (60) @(posedge clk);
    write_cfg(4'b0001, 32'h1F);

    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrun_reset_dark", 64'(ifc.an0_o), 64'h0);
    check("midrun_reset_rd", 64'(ifc.RD), 64'h1F);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      ifc.code0 = 8'($urandom);
      ifc.code1 = 8'($urandom);
      ifc.code2 = 8'($urandom);
      reset = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 11) == 0) ifc.sel0 = 4'(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) ifc.sel1 = 4'(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) ifc.sel2 = ~ifc.sel2;
      if ($urandom_range(0, 15) == 0) begin
        ifc.byteEn = 4'($urandom);
        ifc.WD     = $urandom;
        if ($urandom_range(0, 3) != 0) ifc.WD[4] = 1'b1;
      end else begin
        ifc.byteEn = 4'b0;
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    ifc.byteEn = 4'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
